// File: rtl/grid_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_io_pkg                                                  |
// | Description : Shared mode-bit encoding, reset mode and chain-length helper |
// |               for the grid I/O tile configuration logic.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package grid_io_pkg;

    localparam int CFG_DIR_IN_BIT = 0;
    localparam int CFG_INV_BIT    = 1;

    typedef struct packed {
        logic inv;
        logic dir_in;
    } io_mode_t;

    // Safe state before the first commit: every pad is an input, no inversion.
    localparam io_mode_t CFG_RESET_MODE = '{inv: 1'b0, dir_in: 1'b1};

    function automatic int cfg_len(input int num_subtiles, input int cfg_bits,
                                   input bit parity);
        return num_subtiles * cfg_bits + (parity ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_io_subtile_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_io_subtile_mux                                          |
// | Description : Per-pad direction, isolation and input-invert steering.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module grid_io_subtile_mux
    import grid_io_pkg::*;
(
    input  logic isol_n_i,
    input  logic cfg_valid_i,
    input  logic dir_in_i,
    input  logic inv_i,
    input  logic outpad_i,
    input  logic pad_in_i,
    output logic dir_o,
    output logic pad_out_o,
    output logic inpad_o
);

    logic eff_in;

    // Isolation or an unconfigured tile forces the pad to a quiet input.
    assign eff_in    = ~isol_n_i | ~cfg_valid_i | dir_in_i;
    assign dir_o     = eff_in;
    assign pad_out_o = eff_in ? 1'b0 : outpad_i;
    assign inpad_o   = (eff_in & isol_n_i & cfg_valid_i) ? (pad_in_i ^ inv_i) : 1'b0;

endmodule
`default_nettype wire

// File: rtl/grid_io_tile_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_io_tile_cfg                                             |
// | Description : Grid I/O tile with shadow config chain, counted commit into  |
// |               an active mode register, and safe-state forcing.             |
// |               Optional even-parity bit: define GRID_IO_CFG_PARITY_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module grid_io_tile_cfg
    import grid_io_pkg::*;
#(
    parameter int NUM_SUBTILES = 4,
    parameter int CFG_BITS     = 2
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    IO_ISOL_N,
    input  logic                    ccff_head,
    input  logic                    cfg_shift_en,
    input  logic                    cfg_commit,
    input  logic [NUM_SUBTILES-1:0] io_outpad,
    input  logic [NUM_SUBTILES-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    output logic [NUM_SUBTILES-1:0] io_inpad,
    output logic                    ccff_tail,
    output logic [NUM_SUBTILES-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
    output logic [NUM_SUBTILES-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    output logic                    cfg_valid,
    output logic                    cfg_err
);

`ifdef GRID_IO_CFG_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int L     = cfg_len(NUM_SUBTILES, CFG_BITS, PARITY_EN);
    localparam int CNT_W = $clog2(L + 2);
    localparam int OFS   = PARITY_EN ? 1 : 0;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

    logic [L-1:0]            sr_q,      sr_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [NUM_SUBTILES-1:0] act_dir_q, act_dir_d;
    logic [NUM_SUBTILES-1:0] act_inv_q, act_inv_d;
    logic                    valid_q,   valid_d;
    logic                    err_q,     err_d;

    logic [NUM_SUBTILES-1:0] shadow_dir;
    logic [NUM_SUBTILES-1:0] shadow_inv;
    logic                    parity_ok;
    logic                    commit_ok;

`ifdef GRID_IO_CFG_PARITY_EN
    assign parity_ok = ~(^sr_q);
`else
    assign parity_ok = 1'b1;
`endif

    // A commit coinciding with a shift is always refused.
    assign commit_ok = ~cfg_shift_en & (cnt_q == CNT_FULL) & parity_ok;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        act_dir_d = act_dir_q;
        act_inv_d = act_inv_q;
        valid_d   = valid_q;
        err_d     = err_q;

        if (cfg_shift_en) begin
            sr_d = {sr_q[L-2:0], ccff_head};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (cfg_commit) begin
            cnt_d = '0;
            if (commit_ok) begin
                act_dir_d = shadow_dir;
                act_inv_d = shadow_inv;
                valid_d   = 1'b1;
                err_d     = 1'b0;
            end else begin
                err_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            act_dir_q <= {NUM_SUBTILES{CFG_RESET_MODE.dir_in}};
            act_inv_q <= {NUM_SUBTILES{CFG_RESET_MODE.inv}};
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            act_dir_q <= act_dir_d;
            act_inv_q <= act_inv_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign ccff_tail = sr_q[L-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar i = 0; i < NUM_SUBTILES; i++) begin : g_subtile
        assign shadow_dir[i] = sr_q[OFS + i*CFG_BITS + CFG_DIR_IN_BIT];
        assign shadow_inv[i] = sr_q[OFS + i*CFG_BITS + CFG_INV_BIT];

        grid_io_subtile_mux u_mux (
            .isol_n_i    (IO_ISOL_N),
            .cfg_valid_i (valid_q),
            .dir_in_i    (act_dir_q[i]),
            .inv_i       (act_inv_q[i]),
            .outpad_i    (io_outpad[i]),
            .pad_in_i    (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i]),
            .dir_o       (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i]),
            .pad_out_o   (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i]),
            .inpad_o     (io_inpad[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_io_tile_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_grid_io_tile_cfg                                          |
// | Description : Directed self-checking bench for grid_io_tile_cfg (4 pads).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_grid_io_tile_cfg;

`ifdef GRID_IO_CFG_PARITY_EN
    localparam int TB_L = 9;
`else
    localparam int TB_L = 8;
`endif

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b0;
    logic       IO_ISOL_N = 1'b1;
    logic       ccff_head = 1'b0;
    logic       cfg_shift_en = 1'b0;
    logic       cfg_commit = 1'b0;
    logic [3:0] io_outpad = 4'h0;
    logic [3:0] pad_in = 4'h0;
    logic [3:0] io_inpad;
    logic       ccff_tail;
    logic [3:0] pad_dir;
    logic [3:0] pad_out;
    logic       cfg_valid;
    logic       cfg_err;

    int n_vec = 0;
    int n_err = 0;

    grid_io_tile_cfg #(
        .NUM_SUBTILES (4),
        .CFG_BITS     (2)
    ) dut (
        .prog_clk                         (prog_clk),
        .pReset                           (pReset),
        .IO_ISOL_N                        (IO_ISOL_N),
        .ccff_head                        (ccff_head),
        .cfg_shift_en                     (cfg_shift_en),
        .cfg_commit                       (cfg_commit),
        .io_outpad                        (io_outpad),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
        .io_inpad                         (io_inpad),
        .ccff_tail                        (ccff_tail),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
        .cfg_valid                        (cfg_valid),
        .cfg_err                          (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift1(input logic b, input logic com);
        ccff_head    = b;
        cfg_shift_en = 1'b1;
        cfg_commit   = com;
        step();
        cfg_shift_en = 1'b0;
        cfg_commit   = 1'b0;
    endtask

    task automatic shift_n(input int n, input logic b);
        for (int i = 0; i < n; i++) shift1(b, 1'b0);
    endtask

    // Data MSB first; the parity build appends the even-parity bit last.
    task automatic shift_word(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift1(v[i], 1'b0);
`ifdef GRID_IO_CFG_PARITY_EN
        shift1(^v, 1'b0);
`endif
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic chk_pads(input string tag, input logic [3:0] dir, input logic [3:0] outv,
                            input logic [3:0] inp);
        chk({tag, "_dir"}, 32'(pad_dir), 32'(dir));
        chk({tag, "_out"}, 32'(pad_out), 32'(outv));
        chk({tag, "_inpad"}, 32'(io_inpad), 32'(inp));
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hA5C3;

        // Reset state, with all pad-side inputs driven high.
        io_outpad = 4'hF;
        pad_in    = 4'hF;
        #12;
        chk_pads("reset", 4'hF, 4'h0, 4'h0);
        chk("reset_valid", 32'(cfg_valid), 32'h0);
        chk("reset_err", 32'(cfg_err), 32'h0);
        chk("reset_tail", 32'(ccff_tail), 32'h0);
        @(negedge prog_clk);
        pReset = 1'b1;
        step();
        chk_pads("preconfig", 4'hF, 4'h0, 4'h0);

        // Good commit: pads unchanged while shifting, then DIR=0101.
        shift_word(8'b10_01_00_01);
        chk_pads("midshift", 4'hF, 4'h0, 4'h0);
        commit();
        chk("good_valid", 32'(cfg_valid), 32'h1);
        chk("good_err", 32'(cfg_err), 32'h0);
        chk_pads("good", 4'b0101, 4'b1010, 4'b0101);

        // Short commit is refused and leaves the active modes alone.
        shift_n(TB_L - 1, 1'b0);
        commit();
        chk("short_err", 32'(cfg_err), 32'h1);
        chk("short_valid", 32'(cfg_valid), 32'h1);
        chk("short_dir", 32'(pad_dir), 32'h5);

        // Recovery commit with inversion on input pads.
        shift_word(8'b00_01_11_11);
        commit();
        chk("recov_err", 32'(cfg_err), 32'h0);
        chk_pads("recov_hi", 4'b0111, 4'b1000, 4'b0100);
        pad_in = 4'h0;
        #1;
        chk("recov_lo_inpad", 32'(io_inpad), 32'b0011);
        pad_in = 4'hF;

        // Shift together with commit: shift happens, commit refused, count cleared.
        shift1(1'b0, 1'b0);
        shift_n(TB_L - 2, 1'b1);
        chk("sim_tail_pre", 32'(ccff_tail), 32'h1);
        chk("sim_err_pre", 32'(cfg_err), 32'h0);
        shift1(1'b0, 1'b1);
        chk("sim_tail_post", 32'(ccff_tail), 32'h0);
        chk("sim_err", 32'(cfg_err), 32'h1);
        chk("sim_dir", 32'(pad_dir), 32'h7);
        commit();
        chk("sim_cnt0_err", 32'(cfg_err), 32'h1);
        chk("sim_cnt0_dir", 32'(pad_dir), 32'h7);

        // Isolation overrides an output-configured subtile in the same cycle.
        shift_word(8'b01_01_00_01);
        commit();
        chk("iso_err", 32'(cfg_err), 32'h0);
        io_outpad = 4'b0010;
        #1;
        chk_pads("iso_off", 4'b1101, 4'b0010, 4'b1101);
        IO_ISOL_N = 1'b0;
        #1;
        chk_pads("iso_on", 4'hF, 4'h0, 4'h0);
        IO_ISOL_N = 1'b1;
        #1;
        chk("iso_release_out", 32'(pad_out), 32'b0010);

        // Counter saturates instead of wrapping back to the chain length.
        shift_n(16 + TB_L, 1'b0);
        commit();
        chk("sat_err", 32'(cfg_err), 32'h1);
        chk("sat_dir", 32'(pad_dir), 32'hD);

        // Pass-through: tail is head delayed by exactly the chain length.
        for (int k = 1; k <= 16; k++) begin
            shift1(pat[16-k], 1'b0);
            if (k >= TB_L) chk($sformatf("tail_k%0d", k), 32'(ccff_tail), 32'(pat[15-(k-TB_L)]));
        end

`ifdef GRID_IO_CFG_PARITY_EN
        // Flipped parity is refused; correct parity commits.
        for (int i = 7; i >= 0; i--) shift1(1'b0, 1'b0);
        shift1(1'b1, 1'b0);
        commit();
        chk("par_bad_err", 32'(cfg_err), 32'h1);
        chk("par_bad_valid", 32'(cfg_valid), 32'h1);
        chk("par_bad_dir", 32'(pad_dir), 32'hD);
        shift_word(8'b00_00_00_00);
        commit();
        chk("par_good_err", 32'(cfg_err), 32'h0);
        chk("par_good_dir", 32'(pad_dir), 32'h0);
`endif

        // Asynchronous reset in the middle of a shift.
        io_outpad    = 4'hF;
        ccff_head    = 1'b1;
        cfg_shift_en = 1'b1;
        step();
        #2;
        pReset = 1'b0;
        #1;
        chk_pads("areset", 4'hF, 4'h0, 4'h0);
        chk("areset_valid", 32'(cfg_valid), 32'h0);
        chk("areset_err", 32'(cfg_err), 32'h0);
        chk("areset_tail", 32'(ccff_tail), 32'h0);
        cfg_shift_en = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
        step();
        chk("areset_hold_valid", 32'(cfg_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
